// File: rtl/pararam_wb_banks.sv
// Wishbone classic slave fronting NUM_BANKS interleaved 32-bit RAM banks with a broadcast window.
// Define PARARAM_BCAST_EN to make broadcast-region writes update every bank.
module pararam_wb_banks #(
    parameter int unsigned NUM_BANKS  = 4,
    parameter int unsigned BANK_DEPTH = 64,
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [31:0] acc_cnt
);

    localparam int unsigned W        = $clog2(NUM_BANKS * BANK_DEPTH);
    localparam int unsigned BANK_LOG = $clog2(NUM_BANKS);
    localparam int unsigned BANK_AW  = (BANK_LOG > 0) ? BANK_LOG : 1;
    localparam int unsigned ROW_AW   = $clog2(BANK_DEPTH);
    localparam logic [W-1:0] BANK_MASK = W'(NUM_BANKS - 1);

    typedef enum logic [0:0] {StIdle, StResp} state_e;

    state_e state_q;

    logic [31:0]        mem [NUM_BANKS][BANK_DEPTH];
    logic [W-1:0]       word_idx;
    logic [BANK_AW-1:0] bank_idx;
    logic [ROW_AW-1:0]  row_idx;
    logic [ROW_AW-1:0]  bc_row;
    logic               claim;
    logic               bcast;
    logic               access;
    logic [31:0]        rd_word;
    logic               unused_adr_bits;

    assign word_idx = wbs_adr_i[W+1:2];
    assign bank_idx = BANK_AW'(word_idx & BANK_MASK);
    assign row_idx  = ROW_AW'(word_idx >> BANK_LOG);
    // Broadcast row wraps the full word index onto a single bank's depth.
    assign bc_row   = ROW_AW'(word_idx);
    assign bcast    = wbs_adr_i[W+2];
    assign claim    = wbs_stb_i && wbs_cyc_i && (wbs_adr_i[31:W+3] == BASE_ADDR[31:W+3]);
    assign access   = claim && (state_q == StIdle);
    assign rd_word  = bcast ? mem[0][bc_row] : mem[bank_idx][row_idx];

    assign unused_adr_bits = ^wbs_adr_i[1:0];

    // RAM has no reset; contents survive wb_rst_n.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_n && access && wbs_we_i) begin
            if (!bcast) begin
                for (int b = 0; b < 4; b++) begin
                    if (wbs_sel_i[b]) mem[bank_idx][row_idx][8*b +: 8] <= wbs_dat_i[8*b +: 8];
                end
            end
`ifdef PARARAM_BCAST_EN
            else begin
                for (int unsigned bk = 0; bk < NUM_BANKS; bk++) begin
                    for (int b = 0; b < 4; b++) begin
                        if (wbs_sel_i[b]) begin
                            mem[BANK_AW'(bk)][bc_row][8*b +: 8] <= wbs_dat_i[8*b +: 8];
                        end
                    end
                end
            end
`endif
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q   <= StIdle;
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= 32'h0;
            acc_cnt   <= 32'h0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (claim) begin
                        state_q   <= StResp;
                        wbs_ack_o <= 1'b1;
                        wbs_dat_o <= wbs_we_i ? 32'h0 : rd_word;
                        acc_cnt   <= acc_cnt + 32'd1;
                    end else begin
                        wbs_ack_o <= 1'b0;
                        wbs_dat_o <= 32'h0;
                    end
                end
                StResp: begin
                    state_q   <= StIdle;
                    wbs_ack_o <= 1'b0;
                    wbs_dat_o <= 32'h0;
                end
                default: begin
                    state_q   <= StIdle;
                    wbs_ack_o <= 1'b0;
                    wbs_dat_o <= 32'h0;
                end
            endcase
        end
    end

endmodule

// File: doc/pararam_wb_banks.md
PARARAM_WB_BANKS -- requirements
Module: pararam_wb_banks

Interface
REQ-001 SHALL have parameter NUM_BANKS, default 4, number of independent 32-bit RAM banks (power of two, 1..16).
REQ-002 SHALL have parameter BANK_DEPTH, default 64, words per bank (power of two, 2..256).
REQ-003 SHALL have parameter BASE_ADDR, default 32'h3000_0000, Wishbone base address, aligned to the window size.
REQ-004 SHALL have port wb_clk_i, input, 1, the single clock; all logic is rising-edge.
REQ-005 SHALL have port wb_rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have ports wbs_stb_i, wbs_cyc_i, wbs_we_i, each input, 1, Wishbone classic strobe, cycle and write-enable.
REQ-007 SHALL have port wbs_sel_i, input, 4, byte lane select.
REQ-008 SHALL have ports wbs_adr_i and wbs_dat_i, each input, 32, byte address and write data.
REQ-009 SHALL have port wbs_ack_o, output, 1, transfer acknowledge.
REQ-010 SHALL have port wbs_dat_o, output, 32, read data.
REQ-011 SHALL have port acc_cnt, output, 32, count of completed acknowledged transfers.

Function
REQ-012 SHALL define W = log2(NUM_BANKS*BANK_DEPTH) and a window of 2^(W+3) bytes at BASE_ADDR: lower half = normal region, upper half = broadcast region (address bit W+2 set).
REQ-013 SHALL claim a request only when stb&cyc are high and wbs_adr_i[31:W+3] equals BASE_ADDR[31:W+3]; other requests get no ack and cause no state change.
REQ-014 SHALL form word index = wbs_adr_i[W+1:2], bank = index mod NUM_BANKS (low bits, interleaved), row = index / NUM_BANKS; wbs_adr_i[1:0] are ignored.
REQ-015 SHALL use FSM IDLE -> RESP -> IDLE: a claimed request sampled in IDLE performs the access on that edge, and the next cycle is RESP.
REQ-016 SHALL hold wbs_ack_o high for exactly the RESP cycle, giving ack one cycle after the request is sampled, then return to IDLE, so there is at most one ack every 2 cycles.
REQ-017 SHALL, on a normal write, update only the byte lanes with wbs_sel_i set in bank[bank][row]; sel = 0 still acks and changes nothing.
REQ-018 SHALL, on a normal read, present bank[bank][row] on wbs_dat_o during RESP, and drive wbs_dat_o = 0 in every other cycle.
REQ-019 SHALL, on a broadcast-region read, return bank 0 at row = word index mod BANK_DEPTH.
REQ-020 SHALL ignore stb/cyc while in RESP; a request held high through RESP is re-sampled in the following IDLE cycle, as a new transfer.
REQ-021 SHALL increment acc_cnt by 1 on each RESP cycle, wrapping from 32'hFFFF_FFFF to 0.
REQ-022 SHALL apply the following to cyc dropping while in RESP: the ack still occurs and the access is already committed.

Reset
REQ-023 SHALL, while wb_rst_n is low, immediately force FSM = IDLE, wbs_ack_o = 0, wbs_dat_o = 0 and acc_cnt = 0, independent of the clock.
REQ-024 SHALL leave RAM contents uninitialised by reset; a write committed on the edge before reset assertion is retained.
REQ-025 SHALL, on reset assertion during RESP, abort the ack; the first claimable edge after reset release is the first edge with wb_rst_n high.

Configuration
REQ-026 SHALL recognise the macro PARARAM_BCAST_EN.
REQ-027 SHALL, with PARARAM_BCAST_EN defined, apply a broadcast-region write to row (word index mod BANK_DEPTH) of every bank in the same edge, under wbs_sel_i.
REQ-028 SHALL, without PARARAM_BCAST_EN, ack broadcast-region writes with no RAM change, and keep broadcast reads as in REQ-019.

Verification
REQ-029 SHALL verify write then read: write 32'hA5A5_1234, sel 4'hF, to BASE+0x10 -> ack one cycle after request; read BASE+0x10 -> 32'hA5A5_1234; acc_cnt = 2.
REQ-030 SHALL verify byte lanes: initialise word to 32'h1111_1111, write 32'hFFFF_FFFF with sel 4'b0101 -> readback 32'h11FF_11FF.
REQ-031 SHALL verify interleaving (defaults): BASE+0x0 and BASE+0x4 map to banks 0 and 1, row 0; BASE+0x10 maps to bank 0, row 1; distinct values read back without aliasing.
REQ-032 SHALL verify broadcast with the macro: write 32'hCAFE_F00D to BASE+0x400+0x8 -> rows 2 of all 4 banks (BASE+0x20..0x2C) read 32'hCAFE_F00D; without the macro, those words are unchanged.
REQ-033 SHALL verify address decode: request to BASE+0x800 or 32'h2000_0000 -> no ack for 10 cycles and acc_cnt unchanged.
REQ-034 SHALL verify reset mid-transfer: assert wb_rst_n low during RESP -> ack and wbs_dat_o drop to 0 within the same cycle, and acc_cnt = 0.
